// File: rtl/ipv4_pkg.sv
// Shared definitions for the IPv4/TCP header capture path and its parser.
package ipv4_pkg;

  // Width of the captured header and of the parser's data input.
  localparam int unsigned HDR_W = 320;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDrain,
    StHold
  } cap_state_e;

  // Field MSB positions in the header; byte 0 of the packet sits at HDR_W-1.
  localparam int unsigned IP_VER_IHL_MSB = HDR_W - 1;
  localparam int unsigned IP_TOT_LEN_MSB = HDR_W - 1 - 16;
  localparam int unsigned IP_PROTO_MSB   = HDR_W - 1 - 72;
  localparam int unsigned IP_SRC_MSB     = HDR_W - 1 - 96;
  localparam int unsigned IP_DST_MSB     = HDR_W - 1 - 128;
  localparam int unsigned TCP_SPORT_MSB  = HDR_W - 1 - 160;
  localparam int unsigned TCP_DPORT_MSB  = HDR_W - 1 - 176;
  localparam int unsigned TCP_SEQ_MSB    = HDR_W - 1 - 192;
  localparam int unsigned TCP_FLAGS_MSB  = HDR_W - 1 - 264;

  // MSB bit position of packet byte byte_idx within the header.
  function automatic int unsigned hdr_byte_msb(input int unsigned byte_idx);
    return HDR_W - 1 - 8 * byte_idx;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  // Count register; holds once every bit is set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (inc && !(&count_q)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ipv4_hdr_capture_ctrl.sv
// Assembles the first HDR_W bits of each L3 packet into a header register for
// the combinational IPv4/TCP parser, hands it over with valid/ready and drops
// the payload.
module ipv4_hdr_capture_ctrl #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned HDR_W  = ipv4_pkg::HDR_W,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_startofpacket,
  input  logic              in_endofpacket,
  input  logic [DATA_W-1:0] in_data,
  output logic              hdr_valid,
  input  logic              hdr_ready,
  output logic [HDR_W-1:0]  hdr_data,
  output logic              hdr_short,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  short_count,
  output logic [CNT_W-1:0]  err_count
);
  import ipv4_pkg::*;

  localparam int unsigned BEATS = HDR_W / DATA_W;
  localparam int unsigned IDX_W = $clog2(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  cap_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [HDR_W-1:0] hdr_q, hdr_d;
  logic             hdr_valid_q, hdr_valid_d;
  logic             hdr_short_q, hdr_short_d;
  logic             run_q;
  logic             accept;
  logic             hdr_hs;
  logic             restart;
  logic             wr_en;
  logic             err_inc;

  // Write one beat into header slot `slot`, beat 0 landing in the MSBs.
  function automatic logic [HDR_W-1:0] put_beat(input logic [HDR_W-1:0] h,
                                                input logic [IDX_W-1:0] slot,
                                                input logic [DATA_W-1:0] d);
    logic [HDR_W-1:0] r;
    r = h;
    r[HDR_W - 1 - DATA_W * 32'(slot) -: DATA_W] = d;
    return r;
  endfunction

  assign accept = in_valid && in_ready;
  assign hdr_hs = hdr_valid_q && hdr_ready;

  // Upstream ready per state; run_q keeps it low through reset and the edge after.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StIdle:    in_ready = run_q && !hdr_valid_q;
      StCapture: in_ready = 1'b1;
      // Payload flows freely, but a new SOP waits until the header register is free.
      StDrain:   in_ready = !(hdr_valid_q && in_startofpacket);
      StHold:    in_ready = 1'b0;
      default:   in_ready = 1'b0;
    endcase
  end

  // Next-state, header assembly and error detection.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hdr_d       = hdr_q;
    hdr_valid_d = hdr_valid_q;
    hdr_short_d = hdr_short_q;
    restart     = 1'b0;
    wr_en       = 1'b0;
    err_inc     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (in_startofpacket) restart = 1'b1;
          else                  err_inc = 1'b1;
        end
      end
      StCapture: begin
        if (accept) begin
          if (in_startofpacket) begin
            restart = 1'b1;
            err_inc = 1'b1;
          end else begin
            wr_en = 1'b1;
          end
        end
      end
      StDrain: begin
        if (accept) begin
          if (in_startofpacket) begin
            restart = 1'b1;
            err_inc = 1'b1;
          end else if (in_endofpacket) begin
            state_d = (hdr_valid_q && !hdr_ready) ? StHold : StIdle;
          end
        end
      end
      StHold: begin
        if (hdr_hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (hdr_hs) hdr_valid_d = 1'b0;

    // Restart only happens with hdr_valid low, so the header register is free.
    if (restart) begin
      hdr_d = put_beat('0, '0, in_data);
      idx_d = IDX_W'(1);
      if (in_endofpacket) begin
        hdr_valid_d = 1'b1;
        hdr_short_d = 1'b1;
        idx_d       = '0;
        state_d     = StIdle;
      end else begin
        state_d = StCapture;
      end
    end

    if (wr_en) begin
      hdr_d = put_beat(hdr_q, idx_q, in_data);
      idx_d = idx_q + IDX_W'(1);
      if (idx_q == LAST_IDX) begin
        hdr_valid_d = 1'b1;
        hdr_short_d = 1'b0;
        idx_d       = '0;
        state_d     = in_endofpacket ? StIdle : StDrain;
      end else if (in_endofpacket) begin
        hdr_valid_d = 1'b1;
        hdr_short_d = 1'b1;
        idx_d       = '0;
        state_d     = StIdle;
      end
    end
  end

  // State and header registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      hdr_q       <= '0;
      hdr_valid_q <= 1'b0;
      hdr_short_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hdr_q       <= hdr_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_short_q <= hdr_short_d;
      run_q       <= 1'b1;
    end
  end

  assign hdr_valid = hdr_valid_q;
  assign hdr_data  = hdr_q;
  assign hdr_short = hdr_short_q;

  sat_counter #(.CNT_W(CNT_W)) u_pkt_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (hdr_hs),
    .count   (pkt_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_short_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (hdr_hs && hdr_short_q),
    .count   (short_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (err_inc),
    .count   (err_count)
  );

endmodule

// File: doc/ipv4_hdr_capture_ctrl.md
Name: ipv4_hdr_capture_ctrl

Overview:
- Sequences the combinational IPv4/TCP header parser.
- Accepts an Avalon-ST L3 packet stream (Ethernet header already stripped) in DATA_W-bit beats and assembles the first 320 bits of each packet into a header register that drives the parser's 320-bit data input.
- Presents the header with a valid/ready handshake and discards the payload.
- Applies backpressure upstream while an unconsumed header would otherwise be overwritten.

Parameters:
- DATA_W, 64: input beat width. Must divide 320; only 64 is verified.
- HDR_W, 320: captured header width, equal to the parser data width.
- BEATS, HDR_W/DATA_W (=5): number of beats captured per packet. Derived, not overridable.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk  in  1  single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_startofpacket  in  1  first beat of a packet.
- in_endofpacket  in  1  last beat of a packet.
- in_data  in  DATA_W  beat data; first byte of the packet is in the MSBs.
- hdr_valid  out  1  hdr_data holds a complete header for the parser.
- hdr_ready  in  1  consumer takes the header when hdr_valid && hdr_ready.
- hdr_data  out  HDR_W  header; beat k is placed at [HDR_W-1-k*DATA_W -: DATA_W].
- hdr_short  out  1  packet ended before BEATS beats were captured; missing beats read as zero.
- pkt_count  out  CNT_W  headers emitted (handshakes completed).
- short_count  out  CNT_W  short headers emitted.
- err_count  out  CNT_W  protocol errors.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State = IDLE; beat index = 0.
  - hdr_data = 0; hdr_valid, hdr_short, in_ready = 0.
  - All counters = 0.
  - A reset mid-packet abandons the packet; the upstream source is reset in the same domain.
- States: IDLE, CAPTURE, DRAIN, HOLD.
- IDLE:
  - in_ready = !hdr_valid.
  - Beats accepted without SOP are dropped and increment err_count.
  - An accepted SOP beat clears hdr_data, writes beat 0, sets index = 1.
  - If that beat also has EOP: header complete and short (see completion rules), return to IDLE.
  - Otherwise go to CAPTURE.
- CAPTURE:
  - in_ready = 1. Each accepted beat writes slot [index], then index increments.
  - Accepted beat with SOP: err_count++, capture restarts, and the beat is written as beat 0 of the new packet.
  - Completion on writing slot BEATS-1:
    - hdr_valid rises on the next cycle, hdr_short = 0.
    - Next state is DRAIN if that beat has no EOP, otherwise IDLE.
  - Completion on an EOP beat with index < BEATS-1:
    - hdr_valid rises next cycle with hdr_short = 1; unwritten slots remain zero.
    - Next state is IDLE.
- DRAIN:
  - in_ready = 1; payload beats are discarded. The header handshake may complete in any cycle.
  - An accepted EOP goes to IDLE if the header was consumed this cycle or earlier, otherwise to HOLD.
  - An accepted SOP in DRAIN: err_count++ and treated as a new packet, but only if hdr_valid is low; while hdr_valid is high, SOP is not possible because in_ready = 0.
- HOLD:
  - in_ready = 0.
  - On the hdr_ready handshake go to IDLE; in_ready is 1 in the following cycle.
- hdr_valid:
  - Set one cycle after completion.
  - Cleared on the cycle after the hdr_ready handshake.
  - hdr_data and hdr_short are stable while hdr_valid is high.
  - hdr_data is never written while hdr_valid is high; in_ready gating in IDLE guarantees this.
- Latency: last header beat accepted at cycle N gives hdr_valid = 1 at cycle N+1. Minimum packet-to-packet spacing is 1 idle cycle if hdr_ready is tied high.
- Counters:
  - pkt_count and short_count increment on the hdr handshake.
  - err_count increments on the error events above.
  - All counters saturate at 2^CNT_W-1; no wrap.
- Simultaneous events: a hdr handshake in the same cycle as a new completion cannot occur (single header register, gated by in_ready). Handshake plus EOP in DRAIN goes to IDLE.

Decomposition:
- Shared package ipv4_pkg:
  - HDR_W = 320.
  - State enum {IDLE, CAPTURE, DRAIN, HOLD}.
  - Slice offsets used by the parser, so the parser and this block agree on bit placement.
- One sub-module: sat_counter (parameter CNT_W; inputs inc, clk, reset_n), instantiated three times.
- The parser is instantiated by the parent alongside this block, not inside it.

Test Plan:
- 9-beat packet, SOP on beat 0, EOP on beat 8, beats = 64'h4500_0028_1234_4000 ... , hdr_ready = 1.
  - Required: hdr_valid one cycle after beat 4; hdr_data[319:256] = 64'h4500_0028_1234_4000.
  - Required: beats 5-8 accepted and discarded; pkt_count = 1.
- Same packet with hdr_ready = 0 until 20 cycles after EOP.
  - Required: state HOLD, in_ready = 0 from cycle EOP+1.
  - Required: the second packet's SOP stalls until the cycle after the handshake, and hdr_data is unchanged during the stall.
- 3-beat packet, EOP on beat 2.
  - Required: hdr_short = 1; hdr_data[127:0] = 0; short_count = 1, pkt_count = 1.
- SOP again on capture beat 2 without an EOP.
  - Required: err_count = 1; captured header comes from the second SOP packet's beats only.
- Assert reset_n low for 1 cycle during capture beat 3.
  - Required: all outputs zero asynchronously; the next full packet is captured correctly.
- Preload counters to 2^CNT_W-1 via forced state, then send one packet.
  - Required: pkt_count stays at 2^CNT_W-1.
